// File: rtl/mac_tx_axis_arbiter.sv
// mac_tx_axis_arbiter
//
// Packet-granular round-robin arbiter that shares the MAC Tx AXIS slave
// (s00_axis) between N_PORTS upstream AXIS sources, all in the i_txc domain.
// A port that wins arbitration keeps the grant from its first beat through
// its tlast beat, so packets are never interleaved, even while the MAC
// back-pressures for PCS tx-ready gaps. The datapath is purely combinational:
// the IDLE winner is forwarded in the same cycle it is chosen.
//
// Ports:
//   i_txc           Tx clock shared with MAC/PCS Tx
//   i_tx_reset      synchronous active-high reset
//   i_port_enable   per-port arbitration enable, looked at only in IDLE
//   s_axis_*        packed upstream AXIS sources, port k at slice k
//   m00_axis_*      AXIS master towards the MAC s00_axis slave
//   o_grant         one-hot current selection, zero when nothing selected
//   o_busy          high while a multi-beat packet holds the grant
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no packet in flight; round-robin winner forwarded directly
// ST_LOCKED | first beat of a multi-beat packet sent; mux held until tlast

module mac_tx_axis_arbiter #(
  parameter int N_PORTS    = 2,
  parameter int DATA_WIDTH = 64
) (
  input  logic                              i_txc,
  input  logic                              i_tx_reset,
  input  logic [N_PORTS-1:0]                i_port_enable,
  input  logic [N_PORTS*DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [N_PORTS*(DATA_WIDTH/8)-1:0] s_axis_tkeep,
  input  logic [N_PORTS-1:0]                s_axis_tvalid,
  input  logic [N_PORTS-1:0]                s_axis_tlast,
  output logic [N_PORTS-1:0]                s_axis_tready,
  output logic [DATA_WIDTH-1:0]             m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]           m00_axis_tkeep,
  output logic                              m00_axis_tvalid,
  output logic                              m00_axis_tlast,
  input  logic                              m00_axis_tready,
  output logic [N_PORTS-1:0]                o_grant,
  output logic                              o_busy
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_locked;
  logic [IDX_W-1:0]   r_rr_ptr;

  logic [N_PORTS-1:0] w_req;
  logic               w_req_any;
  logic [IDX_W-1:0]   w_winner;
  logic [IDX_W-1:0]   w_sel;
  logic               w_active;
  logic               w_beat;

  // Index after p, wrapping at N_PORTS (which need not be a power of two).
  function automatic logic [IDX_W-1:0] f_next_idx(input logic [IDX_W-1:0] p);
    if (int'(p) >= N_PORTS - 1) begin
      return '0;
    end
    return p + IDX_W'(1);
  endfunction

  // Round-robin search: scan offsets from the top down so the smallest
  // offset from r_rr_ptr that is requesting is the one left in w_winner.
  always_comb begin
    int idx;
    idx       = 0;
    w_req     = s_axis_tvalid & i_port_enable;
    w_req_any = |w_req;
    w_winner  = r_rr_ptr;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= N_PORTS) begin
        idx = idx - N_PORTS;
      end
      if (w_req[idx]) begin
        w_winner = IDX_W'(idx);
      end
    end
  end

  // Output mux. In LOCKED the grant stays on the locked port even when its
  // tvalid drops mid-packet; underrun handling belongs to the source.
  always_comb begin
    w_sel           = (r_state == ST_LOCKED) ? r_locked : w_winner;
    w_active        = !i_tx_reset && ((r_state == ST_LOCKED) || w_req_any);
    m00_axis_tdata  = '0;
    m00_axis_tkeep  = '0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;
    s_axis_tready   = '0;
    o_grant         = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (w_sel == IDX_W'(k)) begin
        m00_axis_tdata = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        m00_axis_tkeep = s_axis_tkeep[k*KEEP_WIDTH +: KEEP_WIDTH];
        if (w_active) begin
          m00_axis_tvalid  = s_axis_tvalid[k];
          m00_axis_tlast   = s_axis_tlast[k];
          s_axis_tready[k] = m00_axis_tready;
          o_grant[k]       = 1'b1;
        end
      end
    end
    o_busy = !i_tx_reset && (r_state == ST_LOCKED);
    w_beat = m00_axis_tvalid && m00_axis_tready;
  end

  // A single-beat packet never enters LOCKED; it only advances the pointer.
  always_ff @(posedge i_txc) begin
    if (i_tx_reset) begin
      r_state  <= ST_IDLE;
      r_locked <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_beat) begin
            if (m00_axis_tlast) begin
              r_rr_ptr <= f_next_idx(w_winner);
            end else begin
              r_state  <= ST_LOCKED;
              r_locked <= w_winner;
            end
          end
        end
        ST_LOCKED: begin
          if (w_beat && m00_axis_tlast) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= f_next_idx(r_locked);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_axis_arbiter.sv
// Directed bench for mac_tx_axis_arbiter with two ports.
// Each source is a packet queue: payload word = A000 + port*256 + pkt*16 + beat.

module tb_mac_tx_axis_arbiter;

  localparam int NP = 2;
  localparam int DW = 64;
  localparam int KW = DW / 8;

  logic             clk_sys = 1'b0;
  logic             i_tx_reset;
  logic [NP-1:0]    i_port_enable;
  logic [NP*DW-1:0] s_axis_tdata;
  logic [NP*KW-1:0] s_axis_tkeep;
  logic [NP-1:0]    s_axis_tvalid;
  logic [NP-1:0]    s_axis_tlast;
  logic [NP-1:0]    s_axis_tready;
  logic [DW-1:0]    m00_axis_tdata;
  logic [KW-1:0]    m00_axis_tkeep;
  logic             m00_axis_tvalid;
  logic             m00_axis_tlast;
  logic             m00_axis_tready;
  logic [NP-1:0]    o_grant;
  logic             o_busy;

  always #5 clk_sys = ~clk_sys;

  mac_tx_axis_arbiter #(.N_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .i_txc          (clk_sys),
    .i_tx_reset     (i_tx_reset),
    .i_port_enable  (i_port_enable),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .m00_axis_tdata (m00_axis_tdata),
    .m00_axis_tkeep (m00_axis_tkeep),
    .m00_axis_tvalid(m00_axis_tvalid),
    .m00_axis_tlast (m00_axis_tlast),
    .m00_axis_tready(m00_axis_tready),
    .o_grant        (o_grant),
    .o_busy         (o_busy)
  );

  int rem  [NP];
  int len  [NP];
  int beat [NP];
  int pkt  [NP];
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int p, input int n_pkts, input int n_beats);
    rem[p]  = n_pkts;
    len[p]  = n_beats;
    beat[p] = 0;
    pkt[p]  = 0;
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      s_axis_tvalid[p]          = rem[p] > 0;
      s_axis_tlast[p]           = (rem[p] > 0) && (beat[p] == len[p] - 1);
      s_axis_tdata[p*DW +: DW]  = 64'hA000 + 64'(p * 256 + pkt[p] * 16 + beat[p]);
      s_axis_tkeep[p*KW +: KW]  = 8'hFF;
    end
  endtask

  // Capture handshakes before the edge, advance the sources after it.
  task automatic tick();
    logic [NP-1:0] hs;
    hs = s_axis_tvalid & s_axis_tready;
    @(posedge clk_sys);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (hs[p]) begin
        if (beat[p] == len[p] - 1) begin
          beat[p] = 0;
          pkt[p]++;
          rem[p]--;
        end else begin
          beat[p]++;
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input int port, input int pk,
                            input int bt, input logic l, input logic [NP-1:0] g, input logic b);
    check_eq({tag, ".valid"}, 64'(m00_axis_tvalid), 64'(v));
    if (v) begin
      check_eq({tag, ".data"}, m00_axis_tdata, 64'hA000 + 64'(port * 256 + pk * 16 + bt));
      check_eq({tag, ".last"}, 64'(m00_axis_tlast), 64'(l));
      check_eq({tag, ".keep"}, 64'(m00_axis_tkeep), 64'hFF);
    end else begin
      check_eq({tag, ".last"}, 64'(m00_axis_tlast), 64'(0));
    end
    check_eq({tag, ".grant"}, 64'(o_grant), 64'(g));
    check_eq({tag, ".busy"}, 64'(o_busy), 64'(b));
    check_eq({tag, ".sready"}, 64'(s_axis_tready), 64'(g & {NP{m00_axis_tready}}));
  endtask

  initial begin
    i_tx_reset      = 1'b1;
    i_port_enable   = 2'b11;
    m00_axis_tready = 1'b1;
    load(0, 1, 4);
    load(1, 0, 1);
    settle();

    // reset holds everything quiet even with port0 requesting
    expect_out("rst", 1'b0, 0, 0, 0, 1'b0, 2'b00, 1'b0);
    tick();
    tick();
    i_tx_reset = 1'b0;
    #1;

    // single port, 4 beats
    expect_out("single0", 1'b1, 0, 0, 0, 1'b0, 2'b01, 1'b0);
    tick();
    expect_out("single1", 1'b1, 0, 0, 1, 1'b0, 2'b01, 1'b1);
    tick();
    expect_out("single2", 1'b1, 0, 0, 2, 1'b0, 2'b01, 1'b1);
    tick();
    expect_out("single3", 1'b1, 0, 0, 3, 1'b1, 2'b01, 1'b1);
    tick();
    expect_out("single_idle", 1'b0, 0, 0, 0, 1'b0, 2'b00, 1'b0);

    // rr_ptr is now 1: port1 wins a tie, then port0
    load(0, 1, 1);
    load(1, 1, 1);
    settle();
    expect_out("ptr_p1", 1'b1, 1, 0, 0, 1'b1, 2'b10, 1'b0);
    tick();
    expect_out("ptr_p0", 1'b1, 0, 0, 0, 1'b1, 2'b01, 1'b0);
    tick();
    expect_out("ptr_idle", 1'b0, 0, 0, 0, 1'b0, 2'b00, 1'b0);

    // contention from reset: port0 then port1, no bubble, no interleave
    i_tx_reset = 1'b1;
    load(0, 1, 3);
    load(1, 1, 3);
    settle();
    tick();
    i_tx_reset = 1'b0;
    #1;
    for (int c = 0; c < 6; c++) begin
      expect_out("contend", 1'b1, c / 3, 0, c % 3, (c % 3) == 2,
                 (c < 3) ? 2'b01 : 2'b10, (c % 3) != 0);
      tick();
    end
    expect_out("contend_idle", 1'b0, 0, 0, 0, 1'b0, 2'b00, 1'b0);

    // fairness: 4 two-beat packets each, alternating grants
    load(0, 4, 2);
    load(1, 4, 2);
    settle();
    for (int c = 0; c < 16; c++) begin
      expect_out("fair", 1'b1, (c / 2) % 2, c / 4, c % 2, (c % 2) == 1,
                 (((c / 2) % 2) == 1) ? 2'b10 : 2'b01, (c % 2) == 1);
      tick();
    end
    expect_out("fair_idle", 1'b0, 0, 0, 0, 1'b0, 2'b00, 1'b0);

    // back-pressure mid-packet with port1 waiting
    load(0, 1, 4);
    load(1, 1, 2);
    settle();
    expect_out("bp0", 1'b1, 0, 0, 0, 1'b0, 2'b01, 1'b0);
    tick();
    m00_axis_tready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      expect_out("bp_stall", 1'b1, 0, 0, 1, 1'b0, 2'b01, 1'b1);
      tick();
    end
    m00_axis_tready = 1'b1;
    #1;
    expect_out("bp1", 1'b1, 0, 0, 1, 1'b0, 2'b01, 1'b1);
    tick();
    expect_out("bp2", 1'b1, 0, 0, 2, 1'b0, 2'b01, 1'b1);
    tick();
    expect_out("bp3", 1'b1, 0, 0, 3, 1'b1, 2'b01, 1'b1);
    tick();
    expect_out("bp_p1b0", 1'b1, 1, 0, 0, 1'b0, 2'b10, 1'b0);
    tick();
    expect_out("bp_p1b1", 1'b1, 1, 0, 1, 1'b1, 2'b10, 1'b1);
    tick();
    expect_out("bp_idle", 1'b0, 0, 0, 0, 1'b0, 2'b00, 1'b0);

    // enable mask: only port1 served, single-beat packets
    i_port_enable = 2'b10;
    load(0, 2, 1);
    load(1, 2, 1);
    settle();
    expect_out("mask0", 1'b1, 1, 0, 0, 1'b1, 2'b10, 1'b0);
    tick();
    expect_out("mask1", 1'b1, 1, 1, 0, 1'b1, 2'b10, 1'b0);
    tick();
    expect_out("mask_idle", 1'b0, 0, 0, 0, 1'b0, 2'b00, 1'b0);

    // dropping enable on the locked port does not cut the packet
    i_port_enable = 2'b11;
    load(0, 1, 3);
    load(1, 0, 1);
    settle();
    expect_out("dis0", 1'b1, 0, 0, 0, 1'b0, 2'b01, 1'b0);
    tick();
    i_port_enable = 2'b00;
    #1;
    expect_out("dis1", 1'b1, 0, 0, 1, 1'b0, 2'b01, 1'b1);
    tick();
    expect_out("dis2", 1'b1, 0, 0, 2, 1'b1, 2'b01, 1'b1);
    tick();
    expect_out("dis_idle", 1'b0, 0, 0, 0, 1'b0, 2'b00, 1'b0);

    // reset on beat 2 of 5; rr_ptr is 1 here, port1 masked to let port0 start
    i_port_enable = 2'b01;
    load(0, 1, 5);
    load(1, 1, 2);
    settle();
    expect_out("rmid0", 1'b1, 0, 0, 0, 1'b0, 2'b01, 1'b0);
    tick();
    i_port_enable = 2'b11;
    #1;
    expect_out("rmid1", 1'b1, 0, 0, 1, 1'b0, 2'b01, 1'b1);
    tick();
    i_tx_reset = 1'b1;
    #1;
    expect_out("rmid_rst", 1'b0, 0, 0, 0, 1'b0, 2'b00, 1'b0);
    tick();
    expect_out("rmid_rst2", 1'b0, 0, 0, 0, 1'b0, 2'b00, 1'b0);
    i_tx_reset = 1'b0;
    #1;
    expect_out("rmid_after", 1'b1, 0, 0, 2, 1'b0, 2'b01, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_tx_axis_arbiter.md
Name: mac_tx_axis_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single MAC Tx AXIS input between N upstream AXIS sources.
- Sits between the user Tx streams and the MAC's s00_axis slave, in the i_txc domain.
- Never interleaves packets: a grant is held from the first beat through the tlast beat, including across MAC back-pressure caused by PCS tx-ready gaps.
- Zero-latency forwarding: the winner in IDLE is muxed to the output in the same cycle.

Parameters:
N_PORTS, 2, number of upstream requesters (2..8)
DATA_WIDTH, 64, tdata width; tkeep width is DATA_WIDTH/8

Ports:
i_txc  input  1  Tx clock (shared with MAC/PCS Tx)
i_tx_reset  input  1  synchronous active-high reset
i_port_enable  input  N_PORTS  per-port arbitration enable; sampled only at arbitration
s_axis_tdata  input  N_PORTS*DATA_WIDTH  packed upstream data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
s_axis_tkeep  input  N_PORTS*DATA_WIDTH/8  packed upstream keep
s_axis_tvalid  input  N_PORTS  upstream valid
s_axis_tlast  input  N_PORTS  upstream last
s_axis_tready  output  N_PORTS  upstream ready
m00_axis_tdata  output  DATA_WIDTH  to MAC s00_axis_tdata
m00_axis_tkeep  output  DATA_WIDTH/8  to MAC s00_axis_tkeep
m00_axis_tvalid  output  1  to MAC s00_axis_tvalid
m00_axis_tlast  output  1  to MAC s00_axis_tlast
m00_axis_tready  input  1  from MAC s00_axis_tready
o_grant  output  N_PORTS  one-hot current selection, zero if none
o_busy  output  1  high while in LOCKED state

Behaviour:
- Clock and reset: one clock, i_txc. Reset i_tx_reset is synchronous, active-high.
- Reset values:
  - state = IDLE; rr_ptr = 0; locked grant = 0.
  - During reset, combinationally: s_axis_tready = 0, m00_axis_tvalid = 0, m00_axis_tlast = 0, o_grant = 0, o_busy = 0.
- Handshake: "beat" means m00_axis_tvalid & m00_axis_tready.
- State IDLE:
  - req = s_axis_tvalid & i_port_enable.
  - winner = first set bit of req searching upward from rr_ptr with wrap-around, modulo N_PORTS.
  - If req == 0: o_grant = 0, m00_axis_tvalid = 0, all tready = 0.
  - Otherwise winner is forwarded combinationally: m00_axis_* = s_axis_*[winner]; s_axis_tready[winner] = m00_axis_tready; all other tready = 0.
  - Beat with tlast=0: state -> LOCKED, locked grant <= winner.
  - Beat with tlast=1 (single-beat packet): stay IDLE, rr_ptr <= winner+1 (mod N_PORTS).
  - No beat: nothing registered. The winner may change next cycle if requests change; an AXIS source may not drop tvalid once asserted, so this only occurs when higher-priority requests newly arrive.
- State LOCKED:
  - Mux fixed to the locked port. i_port_enable and other ports' tvalid are ignored.
  - Granted tvalid low mid-packet: m00_axis_tvalid = 0. The grant is held; the arbiter does not pad or abort. Underrun avoidance is the source's responsibility.
  - m00_axis_tready low: granted tready low, data held by the source.
  - Beat with tlast=1: state -> IDLE, rr_ptr <= locked+1 (mod N_PORTS). The next packet may start on the following cycle with no bubble.
- Disabling i_port_enable of the locked port mid-packet has no effect until that packet's tlast.
- o_grant and o_busy are valid every cycle; o_busy = (state == LOCKED).
- Reset mid-packet: state returns to IDLE next cycle. The partial packet is truncated at the MAC, which is reset on the same i_tx_reset.
- No registered datapath: latency from input to output is 0 cycles. The only registers are state, the locked index ($clog2(N_PORTS) bits) and rr_ptr.

Test Plan:
- Single port: port0 sends a 4-beat packet with tready=1 -> m00 carries beats 0-3 in consecutive cycles; o_grant=01; o_busy high for cycles 1-3; rr_ptr=1 after tlast.
- Contention: ports 0 and 1 both valid with 3-beat packets from cycle 0 -> port0 packet in cycles 0-2, port1 packet in cycles 3-5; no interleave; s_axis_tready[1]=0 during cycles 0-2.
- Fairness: both ports continuously valid with 2-beat packets for 8 packets -> grant order 0,1,0,1,0,1,0,1.
- Back-pressure: m00_axis_tready low for 3 cycles mid-packet, with port1 also requesting -> output and grant held on port0; port0 beat count unchanged; port1 is not granted until after port0 tlast.
- Enable mask and single-beat: i_port_enable=10, both ports valid with 1-beat packets -> only port1 served, with rr_ptr wrapping to 0 after each; deasserting port0 enable while port0 is LOCKED -> packet completes normally.
- Reset mid-packet: assert i_tx_reset on beat 2 of 5 -> next cycle all tready=0, m00_axis_tvalid=0, o_busy=0; after release, port0 wins first.
